// File: rtl/frame_strobe_sequencer_if.sv
// Command channel between the bitstream loader and the frame strobe sequencer.
// Ports: cmd_valid/cmd_frame/cmd_data from loader, cmd_ready back to loader.
interface frame_strobe_sequencer_if #(
    parameter int FrameBitsPerRow = 32
);
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic [4:0]                 cmd_frame;
    logic [FrameBitsPerRow-1:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_frame,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_frame,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/frame_strobe_sequencer.sv
// Loads one configuration frame into a fabric column: drives FrameData and a
// one-hot FrameStrobe pulse with programmable setup/strobe/hold spacing.
// Ports:
//   UserCLK, reset  : clock, asynchronous active-high reset
//   cmd             : command channel (valid/ready, frame index, frame data)
//   clear_err       : clears the sticky range error
//   FrameData       : registered frame data word to the column
//   FrameStrobe     : registered one-hot strobe, zero outside STROBE
//   busy, done      : not-idle status, one-cycle completion pulse
//   err_range       : sticky out-of-range frame index flag
//   frame_count     : completed valid frame writes (wraps)
module frame_strobe_sequencer #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int SetupCycles     = 1,
    parameter int StrobeCycles    = 2,
    parameter int HoldCycles      = 1
) (
    input  logic                       UserCLK,
    input  logic                       reset,
    frame_strobe_sequencer_if.slave    cmd,
    input  logic                       clear_err,
    output logic [FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic                       busy,
    output logic                       done,
    output logic                       err_range,
    output logic [15:0]                frame_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_e;

    // Phase counters are loaded with length-1 and advance when they hit zero.
    localparam logic [3:0] SetupLd  = 4'(SetupCycles - 1);
    localparam logic [3:0] StrobeLd = 4'(StrobeCycles - 1);
    localparam logic [3:0] HoldLd   = 4'(HoldCycles - 1);

    state_e                     state_q, state_d;
    logic [3:0]                 cnt_q, cnt_d;
    logic [4:0]                 frame_q, frame_d;
    logic [FrameBitsPerRow-1:0] data_q, data_d;
    logic [MaxFramesPerCol-1:0] strobe_q, strobe_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;
    logic [15:0]                fcount_q, fcount_d;

    logic xfer;
    logic idx_ok;

    assign xfer   = cmd.cmd_valid && (state_q == IDLE);
    assign idx_ok = 32'(cmd.cmd_frame) < 32'(MaxFramesPerCol);

    // State register
    always_ff @(posedge UserCLK or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                // Out-of-range commands are consumed but keep us in IDLE.
                if (xfer && idx_ok) begin
                    state_d = SETUP;
                    cnt_d   = SetupLd;
                end
            end
            SETUP: begin
                if (cnt_q == 4'd0) begin
                    state_d = STROBE;
                    cnt_d   = StrobeLd;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d = HOLD;
                    cnt_d   = HoldLd;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Output logic: next values of the registered outputs.
    always_comb begin
        data_d   = data_q;
        frame_d  = frame_q;
        strobe_d = '0;
        done_d   = 1'b0;
        err_d    = err_q;
        fcount_d = fcount_q;

        if (xfer && idx_ok) begin
            data_d  = cmd.cmd_data;
            frame_d = cmd.cmd_frame;
        end

        // Strobe is decoded from the next state so the flop output rises on
        // entry to STROBE and is already low in the first HOLD cycle.
        if (state_d == STROBE) begin
            for (int i = 0; i < MaxFramesPerCol; i++) begin
                strobe_d[i] = (frame_q == 5'(i));
            end
        end

        if (state_q == HOLD && state_d == IDLE) begin
            done_d   = 1'b1;
            fcount_d = fcount_q + 16'd1;
        end

        // A new range error takes priority over a simultaneous clear.
        if (xfer && !idx_ok) begin
            err_d = 1'b1;
        end else if (clear_err) begin
            err_d = 1'b0;
        end
    end

    // Output registers
    always_ff @(posedge UserCLK or posedge reset) begin
        if (reset) begin
            data_q   <= '0;
            frame_q  <= 5'd0;
            strobe_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            fcount_q <= 16'd0;
        end else begin
            data_q   <= data_d;
            frame_q  <= frame_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            err_q    <= err_d;
            fcount_q <= fcount_d;
        end
    end

    assign cmd.cmd_ready = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign FrameData     = data_q;
    assign FrameStrobe   = strobe_q;
    assign done          = done_q;
    assign err_range     = err_q;
    assign frame_count   = fcount_q;

endmodule

// File: tb/tb_frame_strobe_sequencer.sv
// Bench for frame_strobe_sequencer: two instances (default timing and
// setup=3/strobe=1/hold=2) checked every cycle against a timeline model.
module tb_frame_strobe_sequencer;

    localparam int W = 32;
    localparam int N = 20;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    frame_strobe_sequencer_if #(.FrameBitsPerRow(W)) ca ();
    frame_strobe_sequencer_if #(.FrameBitsPerRow(W)) cb ();

    logic          clr_a, clr_b;
    logic [W-1:0]  fd_a, fd_b;
    logic [N-1:0]  fs_a, fs_b;
    logic          busy_a, busy_b, done_a, done_b, err_a, err_b;
    logic [15:0]   cnt_a, cnt_b;

    frame_strobe_sequencer dut_a (
        .UserCLK     (clk),
        .reset       (rst),
        .cmd         (ca.slave),
        .clear_err   (clr_a),
        .FrameData   (fd_a),
        .FrameStrobe (fs_a),
        .busy        (busy_a),
        .done        (done_a),
        .err_range   (err_a),
        .frame_count (cnt_a)
    );

    frame_strobe_sequencer #(
        .SetupCycles  (3),
        .StrobeCycles (1),
        .HoldCycles   (2)
    ) dut_b (
        .UserCLK     (clk),
        .reset       (rst),
        .cmd         (cb.slave),
        .clear_err   (clr_b),
        .FrameData   (fd_b),
        .FrameStrobe (fs_b),
        .busy        (busy_b),
        .done        (done_b),
        .err_range   (err_b),
        .frame_count (cnt_b)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Timeline model: a command accepted at edge t occupies cycles t..t+S+St+H-1,
    // strobes during offsets S..S+St-1 and reports done at offset S+St+H.
    int          ms  [2] = '{1, 3};
    int          mst [2] = '{2, 1};
    int          mh  [2] = '{1, 2};
    bit          m_act  [2];
    int          m_tacc [2];
    logic [4:0]  m_fr   [2];
    logic [W-1:0] m_data[2];
    bit          m_err  [2];
    logic [15:0] m_cnt  [2];
    bit          m_done [2];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mdl_reset();
        for (int d = 0; d < 2; d++) begin
            m_act[d]  = 0;
            m_tacc[d] = 0;
            m_fr[d]   = '0;
            m_data[d] = '0;
            m_err[d]  = 0;
            m_cnt[d]  = '0;
            m_done[d] = 0;
        end
    endtask

    task automatic mdl_edge(input int d, input logic v, input logic [4:0] f,
                            input logic [W-1:0] dat, input logic clr);
        bit rdy;
        rdy       = !m_act[d];
        m_done[d] = 0;
        if (m_act[d] && cyc == m_tacc[d] + ms[d] + mst[d] + mh[d]) begin
            m_done[d] = 1;
            m_cnt[d]  = m_cnt[d] + 16'd1;
            m_act[d]  = 0;
        end
        if (rdy && v && int'(f) < N) begin
            m_act[d]  = 1;
            m_tacc[d] = cyc;
            m_fr[d]   = f;
            m_data[d] = dat;
        end
        if (rdy && v && int'(f) >= N) m_err[d] = 1;
        else if (clr) m_err[d] = 0;
    endtask

    function automatic logic [N-1:0] exp_strobe(input int d);
        logic [N-1:0] s;
        int k;
        s = '0;
        k = cyc - m_tacc[d];
        if (m_act[d] && k >= ms[d] && k < ms[d] + mst[d]) s[m_fr[d]] = 1'b1;
        return s;
    endfunction

    task automatic check_all();
        chk("a_data",   64'(fd_a),        64'(m_data[0]));
        chk("a_strobe", 64'(fs_a),        64'(exp_strobe(0)));
        chk("a_busy",   64'(busy_a),      64'(m_act[0]));
        chk("a_ready",  64'(ca.cmd_ready), 64'(!m_act[0]));
        chk("a_done",   64'(done_a),      64'(m_done[0]));
        chk("a_err",    64'(err_a),       64'(m_err[0]));
        chk("a_count",  64'(cnt_a),       64'(m_cnt[0]));
        chk("b_data",   64'(fd_b),        64'(m_data[1]));
        chk("b_strobe", 64'(fs_b),        64'(exp_strobe(1)));
        chk("b_busy",   64'(busy_b),      64'(m_act[1]));
        chk("b_done",   64'(done_b),      64'(m_done[1]));
        chk("b_err",    64'(err_b),       64'(m_err[1]));
        chk("b_count",  64'(cnt_b),       64'(m_cnt[1]));
    endtask

    // One clock: update the model from the inputs seen at the edge, then check.
    task automatic step();
        @(posedge clk);
        cyc++;
        if (rst) begin
            mdl_reset();
        end else begin
            mdl_edge(0, ca.cmd_valid, ca.cmd_frame, ca.cmd_data, clr_a);
            mdl_edge(1, cb.cmd_valid, cb.cmd_frame, cb.cmd_data, clr_b);
        end
        #1;
        check_all();
    endtask

    task automatic drive_a(input logic v, input logic [4:0] f,
                           input logic [W-1:0] dat, input logic clr);
        ca.cmd_valid = v;
        ca.cmd_frame = f;
        ca.cmd_data  = dat;
        clr_a        = clr;
    endtask

    task automatic drive_b(input logic v, input logic [4:0] f,
                           input logic [W-1:0] dat, input logic clr);
        cb.cmd_valid = v;
        cb.cmd_frame = f;
        cb.cmd_data  = dat;
        clr_b        = clr;
    endtask

    initial begin
        bit ok;
        int last;
        rst = 1'b1;
        drive_a(0, '0, '0, 0);
        drive_b(0, '0, '0, 0);
        mdl_reset();

        // Reset values
        step();
        step();
        #1 rst = 1'b0;

        // Single write of frame 3 on A, frame 11 on B
        drive_a(1, 5'd3, 32'hDEADBEEF, 0);
        drive_b(1, 5'd11, 32'h12345678, 0);
        step();
        drive_a(0, 5'd0, 32'h0, 0);
        drive_b(0, 5'd0, 32'h0, 0);
        repeat (8) step();
        chk("a_single_count", 64'(cnt_a), 64'd1);

        // Back-to-back stream of frames 0..19 with valid held high
        last = 0;
        for (int i = 0; i < N; i++) begin
            drive_a(1, 5'(i), $urandom, 0);
            ok = 0;
            for (int t = 0; t < 10 && !ok; t++) begin
                step();
                if (m_act[0] && m_tacc[0] == cyc) ok = 1;
            end
            chk("stream_accept", 64'(ok), 64'd1);
            if (i > 0) chk("stream_period", 64'(cyc - last), 64'd5);
            last = cyc;
        end
        drive_a(0, 5'd0, 32'h0, 0);
        repeat (6) step();
        chk("stream_count", 64'(cnt_a), 64'd21);
        chk("stream_err", 64'(err_a), 64'd0);

        // Range error, clear racing a new error, then plain clear
        drive_a(1, 5'd20, 32'hAAAA5555, 0);
        step();
        drive_a(1, 5'd25, 32'h5555AAAA, 1);
        step();
        drive_a(0, 5'd0, 32'h0, 1);
        step();
        drive_a(0, 5'd0, 32'h0, 0);
        step();

        // Randomized traffic on both instances
        for (int i = 0; i < 400; i++) begin
            drive_a($urandom_range(1, 0) == 1, 5'($urandom_range(23, 0)),
                    $urandom, $urandom_range(7, 0) == 0);
            drive_b($urandom_range(1, 0) == 1, 5'($urandom_range(23, 0)),
                    $urandom, $urandom_range(7, 0) == 0);
            step();
        end
        drive_a(0, 5'd0, 32'h0, 0);
        drive_b(0, 5'd0, 32'h0, 0);
        repeat (10) step();

        // Asynchronous reset while frame 7 is strobing
        drive_a(1, 5'd7, 32'hCAFEF00D, 0);
        step();
        drive_a(0, 5'd0, 32'h0, 0);
        ok = 0;
        for (int t = 0; t < 10 && !ok; t++) begin
            step();
            if (m_act[0] && cyc - m_tacc[0] == ms[0]) ok = 1;
        end
        chk("rst_reach_strobe", 64'(fs_a), 64'h80);
        rst = 1'b1;
        #1;
        mdl_reset();
        chk("rst_async_strobe", 64'(fs_a), 64'd0);
        chk("rst_async_data", 64'(fd_a), 64'd0);
        check_all();
        step();
        #1 rst = 1'b0;
        step();
        chk("rst_after_ready", 64'(ca.cmd_ready), 64'd1);
        chk("rst_after_count", 64'(cnt_a), 64'd0);

        // frame_count wrap from 65535
        force dut_a.fcount_q = 16'hFFFF;
        m_cnt[0] = 16'hFFFF;
        step();
        step();
        release dut_a.fcount_q;
        step();
        drive_a(1, 5'd19, 32'h0F0F0F0F, 0);
        step();
        drive_a(0, 5'd0, 32'h0, 0);
        ok = 0;
        for (int t = 0; t < 10 && !ok; t++) begin
            step();
            if (m_done[0]) ok = 1;
        end
        chk("wrap_done", 64'(done_a), 64'd1);
        chk("wrap_count", 64'(cnt_a), 64'd0);
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_strobe_sequencer.md
# frame_strobe_sequencer

Configuration-side controller that loads one configuration frame at a time into a fabric column. It accepts frame write commands (frame index plus one row's frame data), drives the column's FrameData bus, and issues a glitch-free, one-hot FrameStrobe pulse with programmable setup, strobe and hold spacing. It sits between the bitstream loader and the FrameStrobe input of the column's bottom/terminal tile. From that tile the strobes ripple through each tile's strobe buffers to every tile in the column.

## Interface
Parameters:
- MaxFramesPerCol, 20: number of frame strobes per column; width of FrameStrobe.
- FrameBitsPerRow, 32: width of frame data word.
- SetupCycles, 1: cycles FrameData is stable before strobe asserts; legal range 1..15.
- StrobeCycles, 2: strobe high time in cycles; legal range 1..15.
- HoldCycles, 1: cycles FrameData is held after strobe deasserts; legal range 1..15.

Ports:
- UserCLK  in  1  the single clock; all state is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE; a command transfers when cmd_valid && cmd_ready.
- cmd_frame  in  5  target frame index.
- cmd_data  in  FrameBitsPerRow  frame data for the selected frame.
- clear_err  in  1  clears err_range.
- FrameData  out  FrameBitsPerRow  registered frame data to the column.
- FrameStrobe  out  MaxFramesPerCol  registered one-hot strobe; all zero outside STROBE.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse marking completion of a valid frame write.
- err_range  out  1  sticky flag; set by a command with cmd_frame >= MaxFramesPerCol.
- frame_count  out  16  count of completed valid frame writes; wraps at 65535 -> 0.

## Operation
- States: IDLE, SETUP, STROBE, HOLD. A 4-bit down-counter times each phase.
- IDLE: cmd_ready=1. On a transfer:
  - Valid index: latch cmd_data into FrameData and cmd_frame into a frame register; load the counter with SetupCycles-1; go to SETUP.
  - Out-of-range index: set err_range, leave FrameData unchanged, issue no strobe, no done pulse, no count increment, and stay in IDLE (cmd_ready stays 1).
- SETUP: when the counter reaches 0, load StrobeCycles-1 and go to STROBE. FrameStrobe is registered so it rises on entry to STROBE.
- STROBE: FrameStrobe[frame]=1 and all other bits 0. When the counter reaches 0, load HoldCycles-1 and go to HOLD. The strobe is 0 in the first HOLD cycle.
- HOLD: FrameData is held. When the counter reaches 0, go to IDLE; done=1 and frame_count+1 in the first IDLE cycle.
- FrameData holds its last value in IDLE until the next valid command.
- clear_err and a new range error in the same cycle: set wins (err_range=1).
- Commands presented while busy are ignored (cmd_ready=0); cmd_valid may stay high.
- Reset values: state IDLE, cmd_ready=1, FrameData=0, FrameStrobe=0, busy=0, done=0, err_range=0, frame_count=0.
- Reset asserted mid-operation forces all outputs to reset values immediately; the strobe drops asynchronously and no done pulse is issued.

## Timing
- All outputs are registered except cmd_ready and busy, which decode directly from the state register.
- With defaults and a transfer at edge T:
  - SETUP is cycle T+1, with FrameData valid.
  - STROBE is cycles T+2 and T+3.
  - HOLD is cycle T+4.
  - IDLE at T+5, with done=1, frame_count updated and cmd_ready=1.
- General: FrameStrobe high for exactly StrobeCycles cycles, starting SetupCycles cycles after FrameData updates. Command period = 1+SetupCycles+StrobeCycles+HoldCycles cycles.
- Back-to-back commands: a new command accepted at T+5 (the done cycle) starts its SETUP at T+6. The strobe never overlaps a FrameData change.
- At most one FrameStrobe bit is high in any cycle; no glitches, since outputs come straight from flops.

## Test plan
- Reset, then cmd_frame=3, cmd_data=32'hDEADBEEF at T -> FrameData=DEADBEEF at T+1; FrameStrobe=20'h00008 at T+2..T+3; 0 at T+4; done=1, frame_count=1 at T+5.
- Streams of 20 commands, frames 0..19 back-to-back with cmd_valid held high -> each strobe is one-hot at bit i, one accept every 5 cycles, frame_count=20, err_range=0.
- cmd_frame=20 -> err_range=1, no strobe, FrameData unchanged, cmd_ready stays 1. Next, clear_err together with cmd_frame=25 -> err_range stays 1. Then clear_err alone -> 0.
- Reset asserted during STROBE of frame 7 -> FrameStrobe=0 and FrameData=0 immediately. After release, cmd_ready=1 and frame_count is unchanged at 0.
- SetupCycles=3, StrobeCycles=1, HoldCycles=2 -> strobe high exactly 1 cycle at T+4, done at T+7.
- Preload frame_count to 65535 via 65535 writes (or a force), then one more valid write -> frame_count=0, done=1.
